// File: rtl/bridge_req_sched.sv
// rtl/bridge_req_sched.sv - single-outstanding request scheduler between bridge_rx, core chain and bridge_tx
//
// Accepts one host request at a time, issues it to the chain head as a
// one-cycle pulse, waits for the chain tail response, and returns read data
// to bridge_tx under a valid/ready handshake. A transaction that sees no
// response within TIMEOUT wait cycles is aborted so the host link cannot hang.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   req_addr_i/req_data_i/req_rw_i request from bridge_rx (rw: 1 = write)
//   req_valid_i / req_ready_o      request handshake
//   addr_o/wdata_o/rw_o            latched request to chain head
//   valid_o                        one-cycle issue pulse to chain head
//   rdata_i / valid_i              response from chain tail
//   res_data_o/res_valid_o         read response to bridge_tx
//   res_ready_i                    bridge_tx ready
//   busy_o                         transaction in progress
//   timeout_o                      one-cycle abort pulse
module bridge_req_sched #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_data_i,
   input  logic                  req_rw_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic                  rw_o,
   output logic                  valid_o,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] res_data_o,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic                  busy_o,
   output logic                  timeout_o
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  rw_q, rw_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
   logic                  res_valid_q, res_valid_d;
   logic                  req_ready_q, req_ready_d;
   logic                  timeout_q, timeout_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rw_q        <= 1'b0;
         valid_q     <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         req_ready_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rw_q        <= rw_d;
         valid_q     <= valid_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         req_ready_q <= req_ready_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rw_d       = rw_q;
      valid_d    = 1'b0;
      res_data_d = res_data_q;
      timeout_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Accept qualifies on the registered ready, so nothing is taken
            // in the first cycle after reset release.
            if (req_valid_i && req_ready_q) begin
               addr_d  = req_addr_i;
               wdata_d = req_data_i;
               rw_d    = req_rw_i;
               valid_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A response in the expiry cycle takes priority over the abort.
            if (valid_i) begin
               if (!rw_q) begin
                  res_data_d = rdata_i;
                  state_d    = S_RESP;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               if (!rw_q) begin
                  res_data_d = '0;
                  state_d    = S_RESP;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (res_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are registered copies of the next state.
   assign req_ready_d = (state_d == S_IDLE);
   assign res_valid_d = (state_d == S_RESP);

   assign req_ready_o = req_ready_q;
   assign addr_o      = addr_q;
   assign wdata_o     = wdata_q;
   assign rw_o        = rw_q;
   assign valid_o     = valid_q;
   assign res_data_o  = res_data_q;
   assign res_valid_o = res_valid_q;
   assign timeout_o   = timeout_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bridge_req_sched.sv
// tb/tb_bridge_req_sched.sv - self-checking bench for bridge_req_sched
module tb_bridge_req_sched;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] req_addr_i;
   logic [DW-1:0] req_data_i;
   logic          req_rw_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] addr_o;
   logic [DW-1:0] wdata_o;
   logic          rw_o;
   logic          valid_o;
   logic [DW-1:0] rdata_i;
   logic          valid_i;
   logic [DW-1:0] res_data_o;
   logic          res_valid_o;
   logic          res_ready_i;
   logic          busy_o;
   logic          timeout_o;

   always #5 clk = ~clk;

   bridge_req_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_rw_i(req_rw_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .addr_o(addr_o), .wdata_o(wdata_o), .rw_o(rw_o), .valid_o(valid_o),
      .rdata_i(rdata_i), .valid_i(valid_i),
      .res_data_o(res_data_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // w: index of the WAIT cycle in which the chain answers (0 = first WAIT
   // cycle, i.e. chain latency w+1 after valid_o); w >= TO means no answer.
   typedef struct {
      bit          rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          w;
      int          rdly;
      bit          hold;
      bit          exp_to;
      logic [15:0] exp_rdata;
      int          exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag, input bit ready_exp);
      check({tag, " req_ready"}, req_ready_o, ready_exp);
      check({tag, " valid_o"}, valid_o, 0);
      check({tag, " res_valid"}, res_valid_o, 0);
      check({tag, " timeout"}, timeout_o, 0);
      check({tag, " busy"}, busy_o, 0);
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int acc_wait, vo_cnt, vo_k, to_cnt, to_k, rs_cnt, rs_k, done_k, weff;
      logic [15:0] a_s, d_s, rd_s;
      logic        rw_s;
      bit          unstable;
      req_addr_i  = v.addr;
      req_data_i  = v.wdata;
      req_rw_i    = v.rw;
      req_valid_i = 1'b1;
      acc_wait = 0;
      while (req_ready_o !== 1'b1 && acc_wait < 50) begin
         step();
         acc_wait++;
      end
      check({tag, " accept_bound"}, acc_wait < 50, 1);
      step();
      if (!v.hold) req_valid_i = 1'b0;
      vo_cnt = 0; vo_k = -1; to_cnt = 0; to_k = -1; rs_cnt = 0; rs_k = -1; done_k = -1;
      a_s = '0; d_s = '0; rd_s = '0; rw_s = 1'b0; unstable = 0;
      for (int k = 0; k < 200; k++) begin
         if (valid_o === 1'b1) begin
            vo_cnt++;
            vo_k = k;
            a_s  = addr_o;
            d_s  = wdata_o;
            rw_s = rw_o;
         end
         if (timeout_o === 1'b1) begin
            to_cnt++;
            to_k = k;
         end
         if (res_valid_o === 1'b1) begin
            if (rs_cnt == 0) begin
               rs_k = k;
               rd_s = res_data_o;
            end else if (res_data_o !== rd_s) begin
               unstable = 1;
            end
            rs_cnt++;
         end
         if (k > 0 && req_ready_o === 1'b1) begin
            done_k = k;
            break;
         end
         valid_i     = (k == v.w + 1);
         rdata_i     = valid_i ? v.rdata : 16'($urandom);
         res_ready_i = (rs_cnt > 0) && (k - rs_k >= v.rdly);
         step();
      end
      valid_i     = 1'b0;
      res_ready_i = 1'b0;

      weff = (v.w < TO) ? v.w : TO - 1;
      check({tag, " valid_o_pulses"}, vo_cnt, 1);
      check({tag, " valid_o_cycle"}, vo_k, 0);
      check({tag, " addr_o"}, a_s, v.addr);
      check({tag, " wdata_o"}, d_s, v.wdata);
      check({tag, " rw_o"}, rw_s, v.rw);
      check({tag, " timeout_pulses"}, to_cnt, v.exp_to);
      if (v.exp_to) check({tag, " timeout_cycle"}, to_k, TO + 1);
      if (v.rw) begin
         check({tag, " write_no_resp"}, rs_cnt, 0);
      end else begin
         check({tag, " resp_cycles"}, rs_cnt, v.rdly + 1);
         check({tag, " resp_start"}, rs_k, weff + 2);
         check({tag, " resp_data"}, rd_s, v.exp_rdata);
         check({tag, " resp_stable"}, unstable, 0);
      end
      check({tag, " ready_return"}, done_k, v.exp_done);
   endtask

   function automatic vec_t model(input bit rw, input logic [15:0] addr, input logic [15:0] wdata,
                                  input logic [15:0] rdata, input int w, input int rdly);
      vec_t v;
      int   answer_cycle;
      v.rw = rw; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.w = w; v.rdly = rdly; v.hold = 0;
      // Chain gets TO wait cycles to answer; after that the scheduler aborts.
      v.exp_to    = (w >= TO);
      v.exp_rdata = v.exp_to ? 16'h0000 : rdata;
      answer_cycle = v.exp_to ? TO - 1 : w;
      v.exp_done  = answer_cycle + 2 + (rw ? 0 : rdly + 1);
      return v;
   endfunction

   initial begin
      rst = 1'b0;
      req_addr_i = '0; req_data_i = '0; req_rw_i = 1'b0; req_valid_i = 1'b0;
      rdata_i = '0; valid_i = 1'b0; res_ready_i = 1'b0;

      //             rw addr     wdata    rdata    w    rdly hold to rdata_exp done
      vecs.push_back('{1, 16'h0003, 16'hBEEF, 16'h0000, 1,   0,  0,  0, 16'h0000, 3});
      vecs.push_back('{0, 16'h0005, 16'h0000, 16'h1234, 2,   0,  0,  0, 16'h1234, 5});
      vecs.push_back('{0, 16'h0011, 16'h0000, 16'hA5A5, 0,   10, 1,  0, 16'hA5A5, 13});
      vecs.push_back('{0, 16'h0022, 16'h0000, 16'hDEAD, 100, 0,  0,  1, 16'h0000, 10});
      vecs.push_back('{1, 16'h0033, 16'hC0DE, 16'h0000, 100, 0,  0,  1, 16'h0000, 9});
      vecs.push_back('{0, 16'h0044, 16'h0000, 16'h5A5A, 7,   0,  0,  0, 16'h5A5A, 10});
      vecs.push_back('{1, 16'h0055, 16'h1357, 16'h0000, 7,   0,  0,  0, 16'h0000, 9});
      vecs.push_back('{0, 16'hFFFF, 16'h0000, 16'hFFFF, 0,   2,  0,  0, 16'hFFFF, 5});

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset", 0);
      check("reset addr_o", addr_o, 0);
      check("reset wdata_o", wdata_o, 0);
      check("reset rw_o", rw_o, 0);
      check("reset res_data", res_data_o, 0);
      rst = 1'b1;
      check("release ready_before_edge", req_ready_o, 0);
      step();
      check("release ready_after_edge", req_ready_o, 1);

      foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Stray chain responses while idle must be ignored.
      valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rdata_i = 16'h1111;
         step();
         check_idle_outputs($sformatf("stray%0d", k), 1);
         check($sformatf("stray%0d res_data", k), res_data_o, 16'hFFFF);
      end
      valid_i = 1'b0;

      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v = model(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
                   $urandom_range(0, TO + 2), $urandom_range(0, 3));
         run_txn(v, $sformatf("rnd%0d", i));
      end

      // Reset while a read is waiting on the chain, then a late response.
      req_addr_i = 16'h0042; req_rw_i = 1'b0; req_valid_i = 1'b1;
      for (int k = 0; k < 50 && req_ready_o !== 1'b1; k++) step();
      step();
      req_valid_i = 1'b0;
      step();
      step();
      check("midrst busy_before", busy_o, 1);
      rst = 1'b0;
      #1;
      check_idle_outputs("midrst", 0);
      check("midrst addr_o", addr_o, 0);
      check("midrst rw_o", rw_o, 0);
      check("midrst res_data", res_data_o, 0);
      step();
      step();
      rst = 1'b1;
      valid_i = 1'b1;
      rdata_i = 16'h7777;
      check("midrst ready_before_edge", req_ready_o, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_idle_outputs($sformatf("late%0d", k), 1);
         check($sformatf("late%0d res_data", k), res_data_o, 0);
      end
      valid_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
